// File: rtl/fu_pkg.sv
// Shared definitions for the VLIW-slot functional unit: opcodes, instruction field
// positions, ALU operation encoding and FSM states.
package fu_pkg;

  localparam logic [5:0] OpSingle = 6'h00;
  localparam logic [5:0] OpOpi    = 6'h01;
  localparam logic [5:0] OpOpr    = 6'h02;
  localparam logic [5:0] OpLui    = 6'h03;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned RdLsb     = 6;
  localparam int unsigned Rs1Lsb    = 11;
  localparam int unsigned Rs2Lsb    = 16;
  localparam int unsigned Imm12Lsb  = 16;
  localparam int unsigned Imm20Lsb  = 11;
  localparam int unsigned F4Lsb     = 28;
  localparam int unsigned F1Bit     = 31;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluXor = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluSub = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6
  } alu_op_t;

  // F4 values above this are undecodable.
  localparam logic [3:0] AluOpMax = 4'd6;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRead,
    StExec,
    StWb
  } fu_state_t;

endpackage

// File: rtl/fu_alu.sv
// Combinational ALU for the functional unit; shifts use the low log2(XLEN) bits of b.
module fu_alu
  import fu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] q
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [ShW-1:0] shamt;
  assign shamt = b[ShW-1:0];

  always_comb begin
    q = '0;
    unique case (op)
      AluAdd:  q = a + b;
      AluXor:  q = a ^ b;
      AluAnd:  q = a & b;
      AluOr:   q = a | b;
      AluSub:  q = a - b;
      AluSll:  q = a << shamt;
      AluSrl:  q = a >> shamt;
      default: q = '0;
    endcase
  end

endmodule

// File: rtl/fu_exec_unit.sv
// One VLIW bundle slot: IDLE->DECODE->READ->EXEC->WB, one instruction per five cycles.
// Optional retired-instruction counter enabled by defining FU_PERF_CNT_EN.
module fu_exec_unit
  import fu_pkg::*;
#(
  parameter int unsigned FUID   = 0,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] bundle_addr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] done_bundle_addr,
  output logic [4:0]        reg_raddr1,
  output logic [4:0]        reg_raddr2,
  output logic              reg_ren,
  input  logic [XLEN-1:0]   reg_rdata1,
  input  logic [XLEN-1:0]   reg_rdata2,
  output logic              reg_we,
  output logic [4:0]        reg_waddr,
  output logic [XLEN-1:0]   reg_wdata
`ifdef FU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_count
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("XLEN must be 32 or 64");
  end
  if (FUID > 255 || CNT_W == 0) begin : g_param_chk
    $error("FUID or CNT_W out of range");
  end

  fu_state_t         state_q, state_d;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   opa_q, opb_q, res_q, alu_q, lui_val;

  logic [5:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm12;
  logic [19:0] imm20;
  logic [3:0]  f4;
  logic        f1, is_alu, legal, writes, accept;
  logic [31:0] lui32;

  assign opcode = instr_q[OpcodeLsb +: 6];
  assign rd     = instr_q[RdLsb +: 5];
  assign rs1    = instr_q[Rs1Lsb +: 5];
  assign rs2    = instr_q[Rs2Lsb +: 5];
  assign imm12  = instr_q[Imm12Lsb +: 12];
  assign imm20  = instr_q[Imm20Lsb +: 20];
  assign f4     = instr_q[F4Lsb +: 4];
  assign f1     = instr_q[F1Bit];

  assign is_alu = (opcode == OpOpi) || (opcode == OpOpr);
  assign legal  = ((opcode == OpSingle) && (instr_q[31:6] == '0)) ||
                  (is_alu && (f4 <= AluOpMax)) || (opcode == OpLui);
  assign writes = legal && (opcode != OpSingle) && (rd != 5'd0);
  assign accept = instr_valid && (state_q == StIdle);

  assign lui32   = {imm20, 12'b0};
  assign lui_val = f1 ? XLEN'($signed(lui32)) : XLEN'(lui32);

  fu_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a (opa_q),
    .b (opb_q),
    .op(alu_op_t'(f4)),
    .q (alu_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: state_d = StRead;
      StRead:   state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= '0;
      addr_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        instr_q <= instruction;
        addr_q  <= bundle_addr;
      end
      // Register file data is valid during READ; capture it for EXEC.
      if (state_q == StRead) begin
        opa_q <= reg_rdata1;
        opb_q <= (opcode == OpOpr) ? reg_rdata2 : XLEN'(imm12);
      end
      if (state_q == StExec) begin
        res_q <= (opcode == OpLui) ? lui_val : alu_q;
      end
    end
  end

  always_comb begin
    instr_ready      = (state_q == StIdle);
    busy             = (state_q != StIdle);
    done             = 1'b0;
    illegal          = 1'b0;
    done_bundle_addr = '0;
    reg_ren          = 1'b0;
    reg_raddr1       = '0;
    reg_raddr2       = '0;
    reg_we           = 1'b0;
    reg_waddr        = '0;
    reg_wdata        = '0;
    unique case (state_q)
      StDecode: begin
        if (is_alu) begin
          reg_ren    = 1'b1;
          reg_raddr1 = rs1;
          reg_raddr2 = (opcode == OpOpr) ? rs2 : 5'd0;
        end
      end
      StWb: begin
        done             = 1'b1;
        illegal          = !legal;
        done_bundle_addr = addr_q;
        if (writes) begin
          reg_we    = 1'b1;
          reg_waddr = rd;
          reg_wdata = res_q;
        end
      end
      default: ;
    endcase
  end

`ifdef FU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_count <= '0;
    end else if (state_q == StWb) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fu_exec_unit.sv
// Self-checking bench for fu_exec_unit: directed cases plus random instructions checked
// against an arithmetic reference model and a static register-file model.
module tb_fu_exec_unit;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [31:0]       instruction = '0;
  logic [ADDR_W-1:0] bundle_addr = '0;
  logic              busy, done, illegal;
  logic [ADDR_W-1:0] done_bundle_addr;
  logic [4:0]        reg_raddr1, reg_raddr2, reg_waddr;
  logic              reg_ren, reg_we;
  logic [XLEN-1:0]   reg_rdata1, reg_rdata2, reg_wdata;
`ifdef FU_PERF_CNT_EN
  logic [CNT_W-1:0]  retired_count;
`endif

  fu_exec_unit #(
    .FUID  (0),
    .XLEN  (XLEN),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .bundle_addr     (bundle_addr),
    .busy            (busy),
    .done            (done),
    .illegal         (illegal),
    .done_bundle_addr(done_bundle_addr),
    .reg_raddr1      (reg_raddr1),
    .reg_raddr2      (reg_raddr2),
    .reg_ren         (reg_ren),
    .reg_rdata1      (reg_rdata1),
    .reg_rdata2      (reg_rdata2),
    .reg_we          (reg_we),
    .reg_waddr       (reg_waddr),
    .reg_wdata       (reg_wdata)
`ifdef FU_PERF_CNT_EN
    ,
    .retired_count   (retired_count)
`endif
  );

  always #5 clk = ~clk;

  // Register file: read-only from the bench's point of view, one-cycle read latency.
  logic [63:0] rf [32];
  always @(posedge clk) begin
    if (reg_ren) begin
      reg_rdata1 <= rf[reg_raddr1];
      reg_rdata2 <= rf[reg_raddr2];
    end
  end

  int errors = 0;
  int checks = 0;

  logic        o_we, o_done, o_ill, o_stray, o_ren;
  logic [4:0]  o_wa, o_ra1, o_ra2;
  logic [63:0] o_wd, o_addr;
  int          o_lat;
  logic [31:0] o_cnt0, o_cnt1;

  function automatic logic [31:0] enc_r(input logic [3:0] f4, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f4, 7'd0, rs2, rs1, rd, 6'h02};
  endfunction

  function automatic logic [31:0] enc_i(input logic [3:0] f4, input logic [11:0] imm,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f4, imm, rs1, rd, 6'h01};
  endfunction

  function automatic logic [31:0] enc_lui(input logic f1, input logic [19:0] imm,
                                          input logic [4:0] rd);
    return {f1, imm, rd, 6'h03};
  endfunction

  function automatic void ref_model(input logic [31:0] ins, output logic we,
                                    output logic [4:0] wa, output logic [63:0] wd,
                                    output logic ill);
    logic [5:0]  opc;
    logic [63:0] a, b;
    logic [31:0] up;
    opc = ins[5:0];
    a   = rf[ins[15:11]];
    b   = (opc == 6'h02) ? rf[ins[20:16]] : {52'd0, ins[27:16]};
    ill = 1'b0;
    wd  = '0;
    case (opc)
      6'h00: ill = (ins[31:6] != 26'd0);
      6'h01, 6'h02: begin
        case (ins[31:28])
          4'd0:    wd = a + b;
          4'd1:    wd = a ^ b;
          4'd2:    wd = a & b;
          4'd3:    wd = a | b;
          4'd4:    wd = a - b;
          4'd5:    wd = a << b[5:0];
          4'd6:    wd = a >> b[5:0];
          default: ill = 1'b1;
        endcase
      end
      6'h03: begin
        up = {ins[30:11], 12'd0};
        wd = ins[31] ? {{32{up[31]}}, up} : {32'd0, up};
      end
      default: ill = 1'b1;
    endcase
    we = !ill && (opc != 6'h00) && (ins[10:6] != 5'd0);
    wa = ins[10:6];
  endfunction

  // Issues one instruction and records what the DUT shows over the following cycles.
  task automatic run_instr(input logic [31:0] ins, input logic [63:0] ba);
    bit got = 0;
    o_lat = -1; o_stray = 0; o_done = 0; o_we = 0; o_ill = 0;
    o_wa = '0; o_wd = '0; o_addr = '0; o_ren = 0; o_ra1 = '0; o_ra2 = '0;
    @(negedge clk);
`ifdef FU_PERF_CNT_EN
    o_cnt0 = retired_count;
`else
    o_cnt0 = '0;
`endif
    instruction = ins; bundle_addr = ba; instr_valid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (instr_ready) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: instr_ready=%b required 1", instr_ready);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o_ren = reg_ren; o_ra1 = reg_raddr1; o_ra2 = reg_raddr2;
      end
      if (done && o_lat < 0) begin
        o_lat = k; o_done = 1; o_we = reg_we; o_wa = reg_waddr; o_wd = reg_wdata;
        o_ill = illegal; o_addr = done_bundle_addr;
      end else if (reg_we || done) begin
        o_stray = 1;
      end
    end
`ifdef FU_PERF_CNT_EN
    o_cnt1 = retired_count;
`else
    o_cnt1 = 32'd1;
`endif
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, illegal, reg_ren, reg_we, reg_raddr1, reg_raddr2, reg_waddr, reg_wdata,
         done_bundle_addr} !== '0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b we=%b ren=%b required ready=1 rest 0",
               instr_ready, busy, done, reg_we, reg_ren);
    end
`ifdef FU_PERF_CNT_EN
    checks++;
    if (retired_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", retired_count);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_opi_add();
    rf[1] = 64'h10;
    run_instr(enc_i(4'd0, 12'h005, 5'd1, 5'd2), 64'hA000);
    checks++;
    if (o_ren !== 1'b1 || o_ra1 !== 5'd1 || o_ra2 !== 5'd0) begin
      errors++;
      $display("FAIL opi_read: ren=%b ra1=%0d ra2=%0d required 1/1/0", o_ren, o_ra1, o_ra2);
    end
    checks++;
    if (o_lat !== 4 || o_we !== 1'b1 || o_wa !== 5'd2 || o_wd !== 64'h15) begin
      errors++;
      $display("FAIL opi_add: lat=%0d we=%b wa=%0d wd=%h required 4/1/2/15",
               o_lat, o_we, o_wa, o_wd);
    end
    checks++;
    if (o_addr !== 64'hA000 || o_stray !== 1'b0) begin
      errors++;
      $display("FAIL opi_addr: addr=%h stray=%b required a000/0", o_addr, o_stray);
    end
  endtask

  task automatic test_lui();
    run_instr(enc_lui(1'b1, 20'h80000, 5'd3), 64'h1);
    checks++;
    if (o_we !== 1'b1 || o_wa !== 5'd3 || o_wd !== 64'hFFFF_FFFF_8000_0000) begin
      errors++;
      $display("FAIL lui_sext: we=%b wa=%0d wd=%h required 1/3/ffffffff80000000",
               o_we, o_wa, o_wd);
    end
    run_instr(enc_lui(1'b0, 20'h80000, 5'd3), 64'h2);
    checks++;
    if (o_we !== 1'b1 || o_wd !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL lui_zext: we=%b wd=%h required 1/0000000080000000", o_we, o_wd);
    end
  endtask

  task automatic test_opr();
    rf[6] = 64'd3; rf[7] = 64'd5; rf[8] = 64'd1; rf[9] = 64'h41;
    run_instr(enc_r(4'd4, 5'd7, 5'd6, 5'd10), 64'h3);
    checks++;
    if (o_ren !== 1'b1 || o_ra1 !== 5'd6 || o_ra2 !== 5'd7) begin
      errors++;
      $display("FAIL opr_read: ren=%b ra1=%0d ra2=%0d required 1/6/7", o_ren, o_ra1, o_ra2);
    end
    checks++;
    if (o_we !== 1'b1 || o_wa !== 5'd10 || o_wd !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL opr_sub: we=%b wa=%0d wd=%h required 1/10/fffffffffffffffe",
               o_we, o_wa, o_wd);
    end
    run_instr(enc_r(4'd5, 5'd9, 5'd8, 5'd11), 64'h4);
    checks++;
    if (o_we !== 1'b1 || o_wd !== 64'h2) begin
      errors++;
      $display("FAIL opr_sll: we=%b wd=%h required 1/2", o_we, o_wd);
    end
    run_instr(enc_r(4'd0, 5'd7, 5'd6, 5'd0), 64'h5);
    checks++;
    if (o_done !== 1'b1 || o_we !== 1'b0 || o_ill !== 1'b0) begin
      errors++;
      $display("FAIL rd0_nowrite: done=%b we=%b ill=%b required 1/0/0", o_done, o_we, o_ill);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] cases [2];
    cases[0] = 32'h0000_003F;
    cases[1] = enc_i(4'd9, 12'h001, 5'd1, 5'd4);
    for (int i = 0; i < 2; i++) begin
      run_instr(cases[i], 64'h77);
      checks++;
      if (o_done !== 1'b1 || o_ill !== 1'b1 || o_we !== 1'b0 || o_lat !== 4) begin
        errors++;
        $display("FAIL illegal_%0d: done=%b ill=%b we=%b lat=%0d required 1/1/0/4",
                 i, o_done, o_ill, o_we, o_lat);
      end
      checks++;
      if (o_cnt1 - o_cnt0 !== 32'd1) begin
        errors++;
        $display("FAIL illegal_count_%0d: delta=%0d required 1", i, o_cnt1 - o_cnt0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    instruction = enc_i(4'd0, 12'h005, 5'd1, 5'd2); bundle_addr = 64'hBEEF;
    instr_valid = 1'b1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b required 1", instr_ready);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, illegal, reg_ren, reg_we, reg_wdata, done_bundle_addr} !== '0 ||
        instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_outputs: ready=%b busy=%b done=%b we=%b required ready=1 rest 0",
               instr_ready, busy, done, reg_we);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      if (reg_we || done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rstmid_nowrite: stray events=%0d required 0", bad);
    end
    rf[1] = 64'h10;
    run_instr(enc_i(4'd0, 12'h005, 5'd1, 5'd2), 64'hC0DE);
    checks++;
    if (o_we !== 1'b1 || o_wd !== 64'h15 || o_addr !== 64'hC0DE) begin
      errors++;
      $display("FAIL rstmid_recover: we=%b wd=%h addr=%h required 1/15/c0de",
               o_we, o_wd, o_addr);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [31:0] prog [N];
    logic        e_we [N];
    logic [4:0]  e_wa [N];
    logic [63:0] e_wd [N];
    logic        e_ill;
    int idx = 0, didx = 0, last = -1;
    for (int i = 0; i < N; i++) begin
      prog[i] = (i % 2 == 0) ? enc_r(4'($urandom_range(0, 6)), 5'($urandom), 5'($urandom),
                                     5'($urandom_range(1, 31)))
                             : enc_i(4'($urandom_range(0, 6)), 12'($urandom), 5'($urandom),
                                     5'($urandom_range(1, 31)));
      ref_model(prog[i], e_we[i], e_wa[i], e_wd[i], e_ill);
    end
    @(negedge clk);
    instruction = prog[0]; bundle_addr = 64'h1000; instr_valid = 1'b1;
    for (int cyc = 0; cyc < N * 5 + 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) begin
        checks++;
        if (didx >= N || reg_we !== e_we[didx] || reg_waddr !== e_wa[didx] ||
            reg_wdata !== e_wd[didx] || done_bundle_addr !== 64'(64'h1000 + didx)) begin
          errors++;
          $display("FAIL b2b_result_%0d: we=%b wa=%0d wd=%h addr=%h", didx, reg_we,
                   reg_waddr, reg_wdata, done_bundle_addr);
        end
        didx++;
      end
      if (instr_ready && idx < N) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 5) begin
            errors++;
            $display("FAIL b2b_interval: got %0d cycles required 5", cyc - last);
          end
        end
        last = cyc;
        idx++;
        @(posedge clk);
        #1;
        if (idx < N) begin
          instruction = prog[idx]; bundle_addr = 64'(64'h1000 + idx);
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (idx !== N || didx !== N) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d completed=%0d required %0d", idx, didx, N);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        e_we, e_ill;
    logic [4:0]  e_wa;
    logic [63:0] e_wd, ba;
    int sel;
    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(0, 9);
      ins = $urandom;
      case (sel)
        0:       ins = 32'd0;
        1:       ins[5:0] = 6'h00;
        2, 3, 4: begin ins[5:0] = 6'h01; ins[31:28] = 4'($urandom_range(0, 7)); end
        5, 6, 7: begin ins[5:0] = 6'h02; ins[31:28] = 4'($urandom_range(0, 7)); end
        8:       ins[5:0] = 6'h03;
        default: ins[5:0] = 6'($urandom_range(4, 63));
      endcase
      ba = {$urandom, $urandom};
      ref_model(ins, e_we, e_wa, e_wd, e_ill);
      run_instr(ins, ba);
      checks++;
      if (o_done !== 1'b1 || o_lat !== 4 || o_ill !== e_ill || o_we !== e_we ||
          o_addr !== ba || o_stray !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d ins=%h: done=%b lat=%0d ill=%b we=%b stray=%b req ill=%b we=%b",
                 n, ins, o_done, o_lat, o_ill, o_we, o_stray, e_ill, e_we);
      end
      if (e_we) begin
        checks++;
        if (o_wa !== e_wa || o_wd !== e_wd) begin
          errors++;
          $display("FAIL rand_data_%0d ins=%h: wa=%0d wd=%h required %0d/%h",
                   n, ins, o_wa, o_wd, e_wa, e_wd);
        end
      end
      checks++;
      if (o_cnt1 - o_cnt0 !== 32'd1) begin
        errors++;
        $display("FAIL rand_count_%0d: delta=%0d required 1", n, o_cnt1 - o_cnt0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[0] = '0;
    test_reset();
    test_opi_add();
    test_lui();
    test_opr();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
